apb_xfer_sched: RTL and testbench

- Sequences a single APB master port between two requesters: a write-request queue and a read-request queue, both fed by the AXI4-Lite front end.
- Arbitrates between the queues round-robin and runs the APB IDLE/SETUP/ACCESS protocol.
- Returns a write response (B) or read data/response (R) toward AXI.
- Adds an ACCESS-phase timeout so a hung slave cannot stall the bridge.

---
 rtl/apb_xfer_sched_pkg.sv | 30 +++
 rtl/apb_xfer_sched_if.sv | 76 +++++++
 rtl/apb_xfer_sched_rr_arb.sv | 37 +++
 rtl/apb_xfer_sched.sv | 174 +++++++++++++++++
 tb/tb_apb_xfer_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_xfer_sched_pkg.sv
// Shared definitions for the APB transfer scheduler: field widths, APB
// response codes, the transfer state machine encoding and the arbiter's
// last-grant marker.
package apb_xfer_sched_pkg;

   localparam int PROT_LEN   = 3;
   localparam int STROBE_LEN = 4;   // DATAWIDTH/8 for the 32-bit build
   localparam int RESP_LEN   = 2;

   localparam logic [RESP_LEN-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_LEN-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } xfer_state_e;

   typedef enum logic {
      GRANT_WRITE = 1'b0,
      GRANT_READ  = 1'b1
   } grant_e;

   // Strobe lanes for a given data width (one per byte).
   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/apb_xfer_sched_if.sv
// Bundle of every handshake/bus signal around the scheduler:
//   wr_*     : write-request queue head (valid/ready pop handshake)
//   rd_*     : read-request queue head
//   b*       : AXI write response channel
//   r*       : AXI read data/response channel
//   p*       : APB master port
// Modport "master" is the scheduler (it masters the APB port and answers
// the request queues); modport "slave" is the surrounding environment
// (queues, AXI response sink, APB completer).
interface apb_xfer_sched_if
   import apb_xfer_sched_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32
);
   localparam int STRB_W = strb_width(DATAWIDTH);

   logic                 wr_valid;
   logic                 wr_ready;
   logic [ADDRWIDTH-1:0] wr_addr;
   logic [DATAWIDTH-1:0] wr_data;
   logic [STRB_W-1:0]    wr_strb;
   logic [PROT_LEN-1:0]  wr_prot;

   logic                 rd_valid;
   logic                 rd_ready;
   logic [ADDRWIDTH-1:0] rd_addr;
   logic [PROT_LEN-1:0]  rd_prot;

   logic                 bvalid;
   logic                 bready;
   logic [RESP_LEN-1:0]  bresp;

   logic                 rvalid;
   logic                 rready;
   logic [DATAWIDTH-1:0] rdata;
   logic [RESP_LEN-1:0]  rresp;

   logic [ADDRWIDTH-1:0] paddr;
   logic [DATAWIDTH-1:0] pwdata;
   logic [STRB_W-1:0]    pstrb;
   logic [PROT_LEN-1:0]  pprot;
   logic                 psel;
   logic                 penable;
   logic                 pwrite;
   logic [DATAWIDTH-1:0] prdata;
   logic                 pready;
   logic                 pslverr;

   modport master (
      input  wr_valid, wr_addr, wr_data, wr_strb, wr_prot,
      output wr_ready,
      input  rd_valid, rd_addr, rd_prot,
      output rd_ready,
      output bvalid, bresp,
      input  bready,
      output rvalid, rdata, rresp,
      input  rready,
      output paddr, pwdata, pstrb, pprot, psel, penable, pwrite,
      input  prdata, pready, pslverr
   );

   modport slave (
      output wr_valid, wr_addr, wr_data, wr_strb, wr_prot,
      input  wr_ready,
      output rd_valid, rd_addr, rd_prot,
      input  rd_ready,
      input  bvalid, bresp,
      output bready,
      input  rvalid, rdata, rresp,
      output rready,
      input  paddr, pwdata, pstrb, pprot, psel, penable, pwrite,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_xfer_sched_rr_arb.sv
// Two-requester round-robin arbiter (write queue vs read queue).
// Ports:
//   clk, rst : clock, async active-high reset
//   en       : grants allowed this cycle (scheduler idle)
//   req_wr   : write request pending
//   req_rd   : read request pending
//   gnt_wr   : write granted (combinational)
//   gnt_rd   : read granted (combinational)
// The last grant resets to READ so a write wins the first tie.
module apb_rr_arb
   import apb_xfer_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);

   grant_e last_q;

   assign gnt_wr = en & req_wr & (~req_rd | (last_q == GRANT_READ));
   assign gnt_rd = en & req_rd & ~gnt_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= GRANT_READ;
      end else if (gnt_wr) begin
         last_q <= GRANT_WRITE;
      end else if (gnt_rd) begin
         last_q <= GRANT_READ;
      end
   end

endmodule

// File: rtl/apb_xfer_sched.sv
// Single-port APB master shared between a write-request queue and a
// read-request queue. Requests are granted round-robin, run through the
// APB SETUP/ACCESS phases, and answered on the AXI B or R channel.
// A watchdog on the ACCESS phase aborts with SLVERR (and zero read data)
// if the completer never raises pready.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : apb_xfer_sched_if.master (request queues, B/R, APB)
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no transfer; grant logic live, wr_ready/rd_ready may fire
// SETUP  | psel=1, penable=0, address/control presented
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | bvalid/rvalid held until the AXI side takes it
module apb_xfer_sched
   import apb_xfer_sched_pkg::*;
#(
   parameter int DATAWIDTH   = 32,
   parameter int ADDRWIDTH   = 32,
   parameter int TIMEOUT_CYC = 256
)(
   input logic               clk,
   input logic               rst,
   apb_xfer_sched_if.master  bus
);

   localparam int STRB_W = strb_width(DATAWIDTH);
   localparam int CNT_W  = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYC - 1);

   xfer_state_e          state_q, state_d;
   logic [CNT_W-1:0]     to_cnt_q;
   logic [ADDRWIDTH-1:0] paddr_q;
   logic [DATAWIDTH-1:0] pwdata_q;
   logic [STRB_W-1:0]    pstrb_q;
   logic [PROT_LEN-1:0]  pprot_q;
   logic                 pwrite_q;
   logic [RESP_LEN-1:0]  resp_q;
   logic [DATAWIDTH-1:0] rdata_q;

   logic gnt_wr, gnt_rd;
   logic timeout_hit;
   logic resp_taken;
   logic psel_c, penable_c, bvalid_c, rvalid_c;

   apb_rr_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (state_q == IDLE),
      .req_wr (bus.wr_valid),
      .req_rd (bus.rd_valid),
      .gnt_wr (gnt_wr),
      .gnt_rd (gnt_rd)
   );

   // Down-counter is loaded with TIMEOUT_CYC-1 on entry to ACCESS, so the
   // terminal count lands on the TIMEOUT_CYC-th ACCESS cycle.
   assign timeout_hit = (to_cnt_q == '0);
   assign resp_taken  = pwrite_q ? bus.bready : bus.rready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_c    = 1'b0;
      penable_c = 1'b0;
      bvalid_c  = 1'b0;
      rvalid_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_wr || gnt_rd) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            psel_c  = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel_c    = 1'b1;
            penable_c = 1'b1;
            if (bus.pready || timeout_hit) begin
               state_d = RESP;
            end
         end
         RESP: begin
            bvalid_c = pwrite_q;
            rvalid_c = ~pwrite_q;
            if (resp_taken) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture, response capture and the ACCESS watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         pprot_q  <= '0;
         pwrite_q <= 1'b0;
         resp_q   <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt_wr) begin
                  paddr_q  <= bus.wr_addr;
                  pwdata_q <= bus.wr_data;
                  pstrb_q  <= bus.wr_strb;
                  pprot_q  <= bus.wr_prot;
                  pwrite_q <= 1'b1;
               end else if (gnt_rd) begin
                  paddr_q  <= bus.rd_addr;
                  pstrb_q  <= '0;
                  pprot_q  <= bus.rd_prot;
                  pwrite_q <= 1'b0;
               end
            end
            SETUP: begin
               to_cnt_q <= TO_LOAD;
            end
            ACCESS: begin
               if (bus.pready) begin
                  resp_q   <= bus.pslverr ? RESP_SLVERR : RESP_OKAY;
                  if (!pwrite_q) begin
                     rdata_q <= bus.prdata;
                  end
                  to_cnt_q <= '0;
               end else if (timeout_hit) begin
                  resp_q   <= RESP_SLVERR;
                  rdata_q  <= '0;
                  to_cnt_q <= '0;
               end else begin
                  to_cnt_q <= to_cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.wr_ready = gnt_wr;
   assign bus.rd_ready = gnt_rd;

   assign bus.psel    = psel_c;
   assign bus.penable = penable_c;
   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
   assign bus.pstrb   = pstrb_q;
   assign bus.pprot   = pprot_q;
   assign bus.pwrite  = pwrite_q;

   assign bus.bvalid = bvalid_c;
   assign bus.bresp  = resp_q;
   assign bus.rvalid = rvalid_c;
   assign bus.rresp  = resp_q;
   assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_apb_xfer_sched.sv
module tb_apb_xfer_sched;
   import apb_xfer_sched_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_xfer_sched_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

   apb_xfer_sched #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          is_wr;
      logic [1:0]    resp;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // wr_ready and rd_ready must never be high together.
   always @(negedge clk) begin
      n_checks++;
      assert (!(bus.wr_ready === 1'b1 && bus.rd_ready === 1'b1)) else begin
         n_err++;
         $error("FAIL ready_exclusive: observed wr_ready=%b rd_ready=%b expected not both 1",
                bus.wr_ready, bus.rd_ready);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, sb.size(), 1);
         return;
      end
      e = sb.pop_front();
      if (e.is_wr) begin
         chk({tag, "_bvalid"}, bus.bvalid, 1'b1);
         chk({tag, "_rvalid_quiet"}, bus.rvalid, 1'b0);
         chk({tag, "_bresp"}, bus.bresp, e.resp);
      end else begin
         chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
         chk({tag, "_bvalid_quiet"}, bus.bvalid, 1'b0);
         chk({tag, "_rresp"}, bus.rresp, e.resp);
         chk({tag, "_rdata"}, bus.rdata, e.data);
      end
   endtask

   task automatic wait_grant(input string tag, output bit got_wr, output bit ok);
      ok = 1'b0;
      got_wr = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (bus.wr_ready === 1'b1 || bus.rd_ready === 1'b1) begin
            ok = 1'b1;
            got_wr = (bus.wr_ready === 1'b1);
            break;
         end
         tick();
      end
      if (!ok) chk({tag, "_grant_timeout"}, ok, 1'b1);
   endtask

   // One complete transfer: grant, SETUP, ACCESS with `waits` wait states,
   // then the response is compared against the scoreboard and taken.
   task automatic xfer(input string tag, input bit exp_wr, input logic [DW-1:0] rdval,
                       input bit err, input int waits, input bit hold);
      bit   got_wr, ok;
      exp_t e;
      wait_grant(tag, got_wr, ok);
      if (!ok) return;
      chk({tag, "_dir"}, got_wr, exp_wr);
      e.is_wr = exp_wr;
      e.resp  = err ? RESP_SLVERR : RESP_OKAY;
      e.data  = exp_wr ? '0 : rdval;
      sb.push_back(e);
      tick();
      if (!hold) begin
         bus.wr_valid = 1'b0;
         bus.rd_valid = 1'b0;
      end
      #1;
      chk({tag, "_setup_psel"}, bus.psel, 1'b1);
      chk({tag, "_setup_penable"}, bus.penable, 1'b0);
      chk({tag, "_pwrite"}, bus.pwrite, exp_wr);
      chk({tag, "_busy_ready"}, bus.wr_ready | bus.rd_ready, 1'b0);
      if (!exp_wr) chk({tag, "_rd_pstrb"}, bus.pstrb, '0);
      bus.pready = 1'b0;
      tick();
      for (int i = 0; i < waits; i++) begin
         chk({tag, "_wait_penable"}, bus.penable, 1'b1);
         tick();
      end
      bus.pready  = 1'b1;
      bus.pslverr = err;
      bus.prdata  = rdval;
      tick();
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'hBAD0_BAD0;
      chk({tag, "_resp_psel"}, bus.psel, 1'b0);
      pop_check(tag);
      bus.bready = 1'b1;
      bus.rready = 1'b1;
      tick();
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      chk({tag, "_done"}, bus.bvalid | bus.rvalid, 1'b0);
   endtask

   initial begin
      bit   got_wr, ok;
      int   n;
      exp_t e;

      rst = 1'b1;
      bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0; bus.wr_prot = '0;
      bus.rd_valid = 0; bus.rd_addr = '0; bus.rd_prot = '0;
      bus.bready = 0; bus.rready = 0;
      bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_psel", bus.psel, 1'b0);
      chk("rst_penable", bus.penable, 1'b0);
      chk("rst_bvalid", bus.bvalid, 1'b0);
      chk("rst_rvalid", bus.rvalid, 1'b0);
      chk("rst_paddr", bus.paddr, '0);
      chk("rst_state", dut.state_q, IDLE);
      rst = 1'b0;
      tick();

      // Single write, zero wait states; pready already high in IDLE/SETUP.
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h10; bus.wr_data = 32'hDEAD_BEEF;
      bus.wr_strb = 4'hF; bus.wr_prot = 3'b010; bus.pready = 1'b1;
      #1;
      chk("t1_wr_ready", bus.wr_ready, 1'b1);
      chk("t1_rd_ready", bus.rd_ready, 1'b0);
      e.is_wr = 1'b1; e.resp = RESP_OKAY; e.data = '0;
      sb.push_back(e);
      tick();
      bus.wr_valid = 1'b0;
      chk("t1_n1_psel", bus.psel, 1'b1);
      chk("t1_n1_penable", bus.penable, 1'b0);
      chk("t1_paddr", bus.paddr, 32'h10);
      chk("t1_pwdata", bus.pwdata, 32'hDEAD_BEEF);
      chk("t1_pstrb", bus.pstrb, 4'hF);
      chk("t1_pprot", bus.pprot, 3'b010);
      chk("t1_pwrite", bus.pwrite, 1'b1);
      tick();
      chk("t1_n2_psel", bus.psel, 1'b1);
      chk("t1_n2_penable", bus.penable, 1'b1);
      chk("t1_n2_paddr", bus.paddr, 32'h10);
      tick();
      chk("t1_n3_psel", bus.psel, 1'b0);
      pop_check("t1");
      bus.pready = 1'b0;
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      chk("t1_n4_bvalid", bus.bvalid, 1'b0);
      chk("t1_n4_state", dut.state_q, IDLE);

      // Single read, 3 wait states, response held 5 cycles with rready low.
      bus.rd_valid = 1'b1; bus.rd_addr = 32'h20; bus.rd_prot = 3'b001;
      #1;
      chk("t2_rd_ready", bus.rd_ready, 1'b1);
      chk("t2_wr_ready", bus.wr_ready, 1'b0);
      e.is_wr = 1'b0; e.resp = RESP_OKAY; e.data = 32'hCAFE_0001;
      sb.push_back(e);
      tick();
      bus.rd_valid = 1'b0;
      chk("t2_psel", bus.psel, 1'b1);
      chk("t2_pwrite", bus.pwrite, 1'b0);
      chk("t2_pstrb", bus.pstrb, 4'h0);
      chk("t2_paddr", bus.paddr, 32'h20);
      chk("t2_pprot", bus.pprot, 3'b001);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t2_wait_penable", bus.penable, 1'b1);
         chk("t2_wait_rvalid", bus.rvalid, 1'b0);
         tick();
      end
      bus.pready = 1'b1; bus.prdata = 32'hCAFE_0001;
      chk("t2_last_penable", bus.penable, 1'b1);
      tick();
      bus.pready = 1'b0; bus.prdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_rvalid", bus.rvalid, 1'b1);
         chk("t2_hold_rdata", bus.rdata, 32'hCAFE_0001);
         chk("t2_hold_rresp", bus.rresp, RESP_OKAY);
         tick();
      end
      pop_check("t2");
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      chk("t2_rvalid_drop", bus.rvalid, 1'b0);

      // Both queues non-empty for 4 transfers: W,R,W,R.
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h100; bus.wr_data = 32'h1111_0000; bus.wr_strb = 4'h3;
      bus.rd_valid = 1'b1; bus.rd_addr = 32'h200;
      for (int k = 0; k < 4; k++) begin
         xfer($sformatf("t3_%0d", k), (k % 2) == 0, 32'h1000 + k, 1'b0, k % 2, 1'b1);
      end
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b0;

      // Write with pslverr, then a normal read.
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h44; bus.wr_data = 32'h0BAD_F00D; bus.wr_strb = 4'h1;
      xfer("t4_err", 1'b1, '0, 1'b1, 1, 1'b0);
      bus.rd_valid = 1'b1; bus.rd_addr = 32'h48;
      xfer("t4_next", 1'b0, 32'h5A5A_0F0F, 1'b0, 0, 1'b0);

      // ACCESS timeout on a read.
      bus.rd_valid = 1'b1; bus.rd_addr = 32'h300;
      wait_grant("t5", got_wr, ok);
      chk("t5_dir", got_wr, 1'b0);
      e.is_wr = 1'b0; e.resp = RESP_SLVERR; e.data = '0;
      sb.push_back(e);
      tick();
      bus.rd_valid = 1'b0; bus.pready = 1'b0; bus.prdata = 32'hFFFF_FFFF;
      tick();
      n = 0;
      while (bus.penable === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      chk("t5_access_cycles", n, TO);
      chk("t5_psel", bus.psel, 1'b0);
      pop_check("t5");
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      chk("t5_rvalid_drop", bus.rvalid, 1'b0);

      // Reset pulse during ACCESS, then a fresh read.
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h400; bus.wr_data = 32'h7777_7777; bus.wr_strb = 4'hF;
      wait_grant("t6", got_wr, ok);
      chk("t6_dir", got_wr, 1'b1);
      tick();
      bus.wr_valid = 1'b0; bus.pready = 1'b0;
      tick();
      chk("t6_in_access", bus.penable, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_rst_psel", bus.psel, 1'b0);
      chk("t6_rst_penable", bus.penable, 1'b0);
      chk("t6_rst_state", dut.state_q, IDLE);
      tick();
      chk("t6_rst_bvalid", bus.bvalid, 1'b0);
      chk("t6_rst_rvalid", bus.rvalid, 1'b0);
      chk("t6_rst_psel2", bus.psel, 1'b0);
      rst = 1'b0;
      tick();
      chk("t6_no_resp_b", bus.bvalid, 1'b0);
      bus.rd_valid = 1'b1; bus.rd_addr = 32'h500;
      xfer("t6_read", 1'b0, 32'hBEEF_1234, 1'b0, 2, 1'b0);

      chk("sb_drained", sb.size(), 0);
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
